// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// master = stream source / memory side, slave = loader.
interface imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Fills the CPU instruction memory from a length-prefixed big-endian byte stream,
// holding the CPU in reset while a load is in progress or after a failed load.
module imem_loader #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    imem_loader_if.slave bus,
    output logic         cpu_rst_out_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [16:0]      DEPTH    = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic [15:0]       n_q;
    logic [ADDR_W-1:0] widx_q;
    logic [1:0]        bcnt_q;
    logic [23:0]       asm_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              xfer;
    logic [15:0]       hdr_d;
    logic              last_word;

    assign xfer      = bus.byte_valid & ready_q;
    assign hdr_d     = {n_q[15:8], bus.byte_in};
    assign last_word = (16'(widx_q) == (n_q - 16'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            widx_q  <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            tmr_q   <= TMR_LOAD;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q <= S_HDR_HI;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        widx_q  <= '0;
                        bcnt_q  <= '0;
                        addr_q  <= '0;
                        tmr_q   <= TMR_LOAD;
                    end
                end
                S_HDR_HI: begin
                    if (xfer) begin
                        n_q[15:8] <= bus.byte_in;
                        state_q   <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        n_q <= hdr_d;
                        if (hdr_d == 16'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end else if ({1'b0, hdr_d} > DEPTH) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_q  <= {asm_q[15:0], bus.byte_in};
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            wdata_q <= {asm_q, bus.byte_in};
                            addr_q  <= widx_q;
                            we_q    <= 1'b1;
                            widx_q  <= widx_q + 1'b1;
                            if (last_word) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Idle watchdog: only active while loading; a transfer always wins over expiry.
            if (busy_q) begin
                if (xfer) begin
                    tmr_q <= TMR_LOAD;
                end else if (tmr_q == '0) begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end else begin
                    tmr_q <= tmr_q - 1'b1;
                end
            end
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign cpu_rst_out_o  = rst | busy_q | err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes the writes an image should produce,
// a negedge monitor pops and compares every imem_we pulse.
module tb_imem_loader;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic cpu_rst_out_o, busy_o, done_o, err_o;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .bus           (bus),
        .cpu_rst_out_o (cpu_rst_out_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr_data", {20'd0, bus.imem_addr, bus.imem_wdata},
                      {20'd0, e.addr, e.data});
            end
        end
    end

    task automatic do_start(input bit with_byte);
        @(negedge clk);
        start_i = 1'b1;
        if (with_byte) begin
            bus.byte_in    = 8'h00;
            bus.byte_valid = 1'b1;
        end
        @(negedge clk);
        start_i        = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check("byte_accept_timeout", 64'(bus.byte_ready), 64'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'(($urandom));
    endtask

    task automatic gap(input int cycles, input bit poke_start);
        for (int g = 0; g < cycles; g++) begin
            check("ready_in_gap", 64'(bus.byte_ready), 64'd1);
            if (poke_start && ($urandom_range(0, 3) == 0)) start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy_o && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("load_finishes", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Reference: header = N big-endian, words big-endian; word k -> address k when N fits.
    task automatic run_image(input logic [15:0] n, input logic [31:0] words[$],
                             input int gap_mode, input bit start_with_byte);
        logic [7:0] bytes[$];
        bit ok;
        ok = (int'(n) <= DEPTH);
        bytes.push_back(n[15:8]);
        bytes.push_back(n[7:0]);
        if (ok) begin
            for (int k = 0; k < int'(n); k++) begin
                wr_t e;
                logic [31:0] w;
                w = words[k];
                bytes.push_back(w[31:24]);
                bytes.push_back(w[23:16]);
                bytes.push_back(w[15:8]);
                bytes.push_back(w[7:0]);
                e.addr = ADDR_W'(k);
                e.data = w;
                exp_q.push_back(e);
            end
        end
        do_start(start_with_byte);
        check("busy_after_start", {62'd0, busy_o, cpu_rst_out_o}, 64'd3);
        check("flags_cleared_on_start", {62'd0, done_o, err_o}, 64'd0);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i]);
            if (i + 1 < bytes.size()) begin
                if (gap_mode == 1)      gap((i % 4 == 3) ? 3 : 1, 1'b0);
                else if (gap_mode == 2) gap($urandom_range(0, 5), 1'b1);
            end
        end
        wait_idle();
        check("done_flag", 64'(done_o), 64'(ok));
        check("err_flag", 64'(err_o), 64'(!ok));
        check("cpu_rst_after_load", 64'(cpu_rst_out_o), 64'(!ok));
        check("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] w[$];
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;

        #12;
        check("reset_outputs", {57'd0, bus.byte_ready, bus.imem_we, busy_o, done_o, err_o,
                                cpu_rst_out_o, 1'b0}, 64'h2);
        check("reset_addr_data", {20'd0, bus.imem_addr, bus.imem_wdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("cpu_released_idle", 64'(cpu_rst_out_o), 64'd0);

        // Two-word image at full rate, then with gaps
        w = '{32'h20080005, 32'h0000000C};
        run_image(16'd2, w, 0, 1'b0);
        run_image(16'd2, w, 1, 1'b0);

        // Empty image
        w = {};
        run_image(16'd0, w, 0, 1'b0);

        // Oversized header, then recovery with a 1-word image
        run_image(16'h1001, w, 0, 1'b0);
        w = '{32'hDEADBEEF};
        run_image(16'd1, w, 0, 1'b0);

        // Byte offered together with start in IDLE must be ignored
        w = '{32'hCAFEF00D};
        run_image(16'd1, w, 0, 1'b1);

        // Timeout after a partial word
        do_start(1'b0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("no_err_before_timeout", {62'd0, busy_o, err_o}, 64'h2);
        @(negedge clk);
        check("err_at_timeout", {61'd0, busy_o, err_o, cpu_rst_out_o}, 64'h3);
        repeat (2) @(negedge clk);
        check("timeout_no_write", 64'(exp_q.size()), 64'd0);

        // Reset after 6 data bytes of a 2-word load
        begin
            wr_t e;
            e.addr = '0;
            e.data = 32'h11223344;
            exp_q.push_back(e);
        end
        do_start(1'b0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        #2 rst = 1'b1;
        #1;
        check("mid_reset_state", {60'd0, busy_o, bus.imem_we, bus.byte_ready, cpu_rst_out_o},
              64'h1);
        check("mid_reset_pending", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_reset_release", {61'd0, cpu_rst_out_o, done_o, err_o}, 64'd0);

        // Reset while the write pulse is high drops it asynchronously
        begin
            wr_t e;
            e.addr = '0;
            e.data = 32'h01020304;
            exp_q.push_back(e);
        end
        do_start(1'b0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        #1;
        check("we_pulse_before_reset", 64'(bus.imem_we), 64'd1);
        rst = 1'b1;
        #1;
        check("we_async_drop", 64'(bus.imem_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("async_pending", 64'(exp_q.size()), 64'd0);

        // Randomised images with random gaps and ignored start pulses
        for (int r = 0; r < 25; r++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            w = {};
            for (int k = 0; k < n; k++) w.push_back($urandom);
            run_image(16'(n), w, 2, 1'b0);
        end

        // Full-depth image
        w = {};
        for (int k = 0; k < DEPTH; k++) w.push_back(32'(k) * 32'h9E3779B9 ^ 32'h5A5A0000);
        run_image(16'(DEPTH), w, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
